// File: rtl/fc_single_layer_if.sv
// Layer-memory port and controller handshake for fc_single_layer.
// The engine is the master: it drives addresses, write strobes and status.
interface fc_single_layer_if;
    logic               enable;
    logic signed [15:0] input_value;
    logic               we;
    logic signed [15:0] out;
    logic [15:0]        addr;
    logic               com_end;
    logic               layer_end;

    modport master (
        input  enable,
        input  input_value,
        output we,
        output out,
        output addr,
        output com_end,
        output layer_end
    );

    modport slave (
        output enable,
        output input_value,
        input  we,
        input  out,
        input  addr,
        input  com_end,
        input  layer_end
    );
endinterface

// File: rtl/fc_single_layer.sv
// One fully-connected layer: buffers FRT_CELL Q8.8 activations, then computes
// BCK_CELL dot products with one multiply-accumulate per cycle over a single memory port.
//
// state | meaning
// IDLE  | waiting for enable
// LOAD  | issuing input addresses 0..FRT_CELL-1
// MAC   | issuing FRT_CELL weight addresses for the current neuron
// DRAIN | no new address; last product lands in the accumulator
// WRITE | result write, com_end (and layer_end on the last neuron)
module fc_single_layer #(
    parameter int FRT_CELL  = 14,
    parameter int BCK_CELL  = 10,
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    fc_single_layer_if.master  bus
);
    localparam int SW = (FRT_CELL > 1) ? $clog2(FRT_CELL) : 1;
    localparam int NW = (BCK_CELL > 1) ? $clog2(BCK_CELL) : 1;
    localparam logic [15:0]   RES_BASE    = 16'(FRT_CELL * (1 + BCK_CELL));
    localparam logic [15:0]   W_BASE      = 16'(FRT_CELL);
    localparam logic [SW-1:0] SLOT_LAST   = SW'(FRT_CELL - 1);
    localparam logic [NW-1:0] NEURON_LAST = NW'(BCK_CELL - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, DRAIN, WRITE} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_X, TAG_W} tag_t;

    state_t             state;
    tag_t               tag_kind;
    logic [SW-1:0]      tag_slot;
    logic [SW-1:0]      slot;
    logic [SW-1:0]      remain;
    logic [NW-1:0]      neuron;
    logic [15:0]        w_next;
    logic signed [39:0] acc;
    logic signed [15:0] x_buf [FRT_CELL];

    logic signed [31:0] prod;
    logic signed [39:0] acc_next;
    logic signed [39:0] acc_shift;
    logic signed [15:0] y_sat;

    // The tag describes the address issued last cycle, whose data is on input_value now.
    always_comb begin
        prod     = bus.input_value * x_buf[tag_slot];
        acc_next = acc;
        if (tag_kind == TAG_W)
            acc_next = acc + 40'(prod);
        acc_shift = acc_next >>> FRAC_BITS;
        if (acc_shift > 40'sd32767)
            y_sat = 16'sh7fff;
        else if (acc_shift < -40'sd32768)
            y_sat = 16'sh8000;
        else
            y_sat = acc_shift[15:0];
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int k = 0; k < FRT_CELL; k++)
                x_buf[k] <= '0;
        end else if (tag_kind == TAG_X) begin
            x_buf[tag_slot] <= bus.input_value;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state         <= IDLE;
            tag_kind      <= TAG_NONE;
            tag_slot      <= '0;
            slot          <= '0;
            remain        <= '0;
            neuron        <= '0;
            w_next        <= W_BASE;
            acc           <= '0;
            bus.we        <= 1'b0;
            bus.out       <= '0;
            bus.addr      <= '0;
            bus.com_end   <= 1'b0;
            bus.layer_end <= 1'b0;
        end else begin
            acc           <= acc_next;
            tag_kind      <= TAG_NONE;
            bus.we        <= 1'b0;
            bus.com_end   <= 1'b0;
            bus.layer_end <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state    <= LOAD;
                        bus.addr <= '0;
                        slot     <= '0;
                        remain   <= SLOT_LAST;
                        neuron   <= '0;
                        w_next   <= W_BASE;
                    end
                end
                LOAD: begin
                    tag_kind <= TAG_X;
                    tag_slot <= slot;
                    if (remain == '0) begin
                        state    <= MAC;
                        bus.addr <= w_next;
                        slot     <= '0;
                        remain   <= SLOT_LAST;
                        acc      <= '0;
                    end else begin
                        bus.addr <= bus.addr + 16'd1;
                        slot     <= slot + 1'b1;
                        remain   <= remain - 1'b1;
                    end
                end
                MAC: begin
                    tag_kind <= TAG_W;
                    tag_slot <= slot;
                    if (remain == '0) begin
                        state  <= DRAIN;
                        w_next <= bus.addr + 16'd1;
                    end else begin
                        bus.addr <= bus.addr + 16'd1;
                        slot     <= slot + 1'b1;
                        remain   <= remain - 1'b1;
                    end
                end
                DRAIN: begin
                    state         <= WRITE;
                    bus.we        <= 1'b1;
                    bus.com_end   <= 1'b1;
                    bus.layer_end <= (neuron == NEURON_LAST);
                    bus.out       <= y_sat;
                    bus.addr      <= RES_BASE + 16'(neuron);
                end
                WRITE: begin
                    if (neuron == NEURON_LAST) begin
                        state <= IDLE;
                    end else begin
                        state    <= MAC;
                        neuron   <= neuron + 1'b1;
                        bus.addr <= w_next;
                        slot     <= '0;
                        remain   <= SLOT_LAST;
                        acc      <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_single_layer.sv
// Directed bench for fc_single_layer: memory model, reference dot products pushed to a
// scoreboard at layer start, and every write checked for address, value, flags and cycle.
module tb_fc_single_layer;
    localparam int F = 14;
    localparam int B = 10;

    typedef struct {
        logic [15:0]        addr;
        logic signed [15:0] out;
        logic               last;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    fc_single_layer_if bus ();

    fc_single_layer #(.FRT_CELL(F), .BCK_CELL(B), .FRAC_BITS(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic signed [15:0] mem [0:255];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    exp_t sb[$];
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) bus.input_value <= mem[bus.addr[7:0]];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference: full-precision dot product, arithmetic shift, saturate.
    task automatic push_layer(input int t0);
        exp_t   n;
        longint acc;
        longint y;
        for (int j = 0; j < B; j++) begin
            acc = 0;
            for (int i = 0; i < F; i++)
                acc += longint'(mem[i]) * longint'(mem[F + j * F + i]);
            y = acc >>> 8;
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            n.addr = 16'(F * (1 + B) + j);
            n.out  = 16'(y);
            n.last = (j == B - 1);
            n.cyc  = t0 + 2 * F + 2 + j * (F + 2) - 1;
            sb.push_back(n);
        end
    endtask

    task automatic start(output int t0, input bit hold);
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        if (!hold) bus.enable = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic fill_const(input logic signed [15:0] xv, input logic signed [15:0] wv);
        for (int k = 0; k < F; k++) mem[k] = xv;
        for (int k = F; k < F * (1 + B); k++) mem[k] = wv;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < F * (1 + B); k++) mem[k] = 16'($urandom_range(0, 2047) - 1024);
    endtask

    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", 32'(bus.addr), -1);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(bus.addr), 32'(mon_e.addr));
                chk("wr_out", bus.out, mon_e.out);
                chk("wr_com_end", bus.com_end, 1);
                chk("wr_layer_end", bus.layer_end, 32'(mon_e.last));
                chk("wr_cycle", cyc, mon_e.cyc);
            end
        end else begin
            chk("com_end_quiet", bus.com_end, 0);
            chk("layer_end_quiet", bus.layer_end, 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int wc;
        bus.enable = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", bus.we, 0);
        chk("rst_com_end", bus.com_end, 0);
        chk("rst_layer_end", bus.layer_end, 0);
        chk("rst_out", bus.out, 0);
        chk("rst_addr", 32'(bus.addr), 0);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);

        // 1.0 x 1.0, enable pulsed for one cycle; LOAD address sequence and idle hold
        fill_const(16'sd256, 16'sd256);
        start(t0, 1'b0);
        push_layer(t0);
        for (int k = 0; k < F; k++) begin
            @(negedge clk);
            chk("load_addr", 32'(bus.addr), k);
        end
        wait_drain(400);
        while (cyc < t0 + 175) @(negedge clk);
        chk("idle_addr_hold", 32'(bus.addr), F * (1 + B) + B - 1);
        chk("idle_we", bus.we, 0);
        repeat (5) @(negedge clk);

        // Ascending inputs, weights -1.0
        for (int k = 0; k < F; k++) mem[k] = 16'(k + 1);
        for (int k = F; k < F * (1 + B); k++) mem[k] = -16'sd256;
        start(t0, 1'b0);
        push_layer(t0);
        chk("sb_expect_m105", sb[0].out, -105);
        wait_drain(400);
        repeat (3) @(negedge clk);

        // Positive and negative saturation
        fill_const(16'sh7fff, 16'sh7fff);
        start(t0, 1'b0);
        push_layer(t0);
        wait_drain(400);
        repeat (3) @(negedge clk);
        fill_const(16'sh7fff, 16'sh8000);
        start(t0, 1'b0);
        push_layer(t0);
        wait_drain(400);
        repeat (3) @(negedge clk);

        // Reset in the middle of neuron 0's MAC phase
        fill_rand();
        start(t0, 1'b0);
        push_layer(t0);
        repeat (19) @(negedge clk);
        #1 reset_n = 1'b1;
        #1;
        chk("midrst_we", bus.we, 0);
        chk("midrst_com_end", bus.com_end, 0);
        chk("midrst_layer_end", bus.layer_end, 0);
        chk("midrst_out", bus.out, 0);
        chk("midrst_addr", 32'(bus.addr), 0);
        sb.delete();
        wc = wr_count;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_write_after_reset", wr_count - wc, 0);
        chk("post_reset_addr", 32'(bus.addr), 0);

        // enable held: back-to-back layers with identical results
        fill_rand();
        start(t0, 1'b1);
        push_layer(t0);
        push_layer(t0 + 175);
        while (cyc < t0 + 175) @(negedge clk);
        chk("relaunch_addr", 32'(bus.addr), 0);
        chk("relaunch_we", bus.we, 0);
        bus.enable = 1'b0;
        wait_drain(600);
        wc = wr_count;
        repeat (30) @(negedge clk);
        chk("no_third_layer", wr_count - wc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fc_single_layer.md
# fc_single_layer

Sequencer and multiply-accumulate engine for one fully-connected neural-network layer with FRT_CELL inputs and BCK_CELL outputs. It reads activations and weights as signed Q8.8 words over a single-port memory interface (`addr`/`input_value`). It computes each output neuron as a dot product and writes each result back through the same port (`we`/`out`/`addr`). It sits between the layer memory and the network-level controller, which starts it with `enable` and watches `com_end`/`layer_end`.

## Interface
- FRT_CELL, 14: number of input activations (front cells), 1..31.
- BCK_CELL, 10: number of output neurons (back cells), 1..31.
- FRAC_BITS, 8: fractional bits of the Q-format; the output is the accumulator arithmetically shifted right by this amount.
- clk  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-high reset (keeps the codebase port name; asserted = 1).
- enable  input  1  start request, level-sampled only in IDLE.
- input_value  input  16  signed memory read data; valid one cycle after its address is presented.
- we  output  1  write strobe; `addr`/`out` form a write when high.
- out  output  16  signed Q8.8 neuron result, valid when `we`=1.
- addr  output  16  read address, or write address when `we`=1.
- com_end  output  1  one-cycle pulse per finished neuron, coincident with `we`.
- layer_end  output  1  one-cycle pulse on the last neuron's write.

## Operation
- Memory map:
  - inputs x[i] at address i, for i = 0..FRT_CELL-1.
  - weight w[j][i] at FRT_CELL + j·FRT_CELL + i.
  - result y[j] written to FRT_CELL·(1+BCK_CELL) + j. With the defaults this is 154..163.
- FSM states: IDLE, LOAD, MAC, DRAIN, WRITE.
  - IDLE -> LOAD when enable=1.
  - LOAD issues addresses 0..FRT_CELL-1 on consecutive cycles, then goes to MAC.
  - MAC issues FRT_CELL weight addresses for neuron j, then goes to DRAIN.
  - DRAIN issues no new address; `addr` holds its last value. It then goes to WRITE.
  - WRITE -> MAC for the next neuron, or -> IDLE after neuron BCK_CELL-1.
- Read pipeline: a one-stage tag register records what each issued address was (input slot i, or weight). On the following edge `input_value` is either stored into an internal 16-bit input buffer x[i], or multiplied with the matching buffered x[i] and added to the accumulator. Loading x[FRT_CELL-1] overlaps the first MAC cycle.
- Arithmetic:
  - Each product is 16×16 signed, giving 32 bits.
  - The accumulator is signed, 40 bits, and is cleared on entry to MAC for each neuron.
  - y = acc >>> FRAC_BITS, saturated to [-32768, 32767].
- WRITE cycle outputs: we=1, com_end=1, addr = result address, out = y. layer_end=1 additionally when j = BCK_CELL-1.
- Outside WRITE: we, com_end and layer_end are 0, and out holds its last value.
- enable changes outside IDLE are ignored; a started layer always completes.
- If enable is still high in IDLE after completion, a new layer starts immediately and all inputs are re-read.

## Timing
- Reset: we=0, com_end=0, layer_end=0, out=0, addr=0, FSM=IDLE, accumulator and buffer cleared. Asserting reset mid-layer aborts it with no further writes.
- Cycle numbering: cycle 1 is the first cycle after the edge that samples enable=1 in IDLE.
- LOAD: cycles 1..FRT_CELL, addr = cycle-1.
- Neuron j MAC: cycles FRT_CELL+1+j·(FRT_CELL+2) through +FRT_CELL-1.
- Neuron j DRAIN: the next cycle after MAC.
- Neuron j WRITE: cycle 2·FRT_CELL+2+j·(FRT_CELL+2). With the defaults this is 30, 46, …, 174.
- Layer latency: FRT_CELL + BCK_CELL·(FRT_CELL+2) cycles (174 with defaults). IDLE is entered the cycle after the last WRITE.
- Throughput: one MAC per cycle, no stalls. The memory must return data exactly one cycle after the address.

## Test plan
- Reset asserted mid-MAC -> all outputs 0 immediately; after release there are no writes until enable.
- All x = 256, all w = 256 (1.0 each), defaults -> ten writes, out = 3584, addr 154..163, com_end with each write, layer_end only at addr 163.
- x[i] = i+1 (raw 1..14), all w = -256 -> every out = -105.
- Saturation: all x = w = 32767 -> out = 32767. All x = 32767 and w = -32768 -> out = -32768.
- Timing: enable pulsed 1 cycle -> addr 0..13 in cycles 1..14, first we at cycle 30, writes every 16 cycles, last at 174, FSM back in IDLE by cycle 175; the enable drop causes no abort.
- enable held high -> after layer_end, a second layer starts with LOAD (addr 0) in cycle 176 and produces identical results.
